// File: rtl/collision_search_controller_pkg.sv
// Shared constants for the SHA-1 partial-collision search controller:
// opcodes, controller states, status-word bit positions and the reject code.
package collision_search_controller_pkg;

  localparam logic [2:0] OP_LOAD     = 3'd0;
  localparam logic [2:0] OP_START    = 3'd1;
  localparam logic [2:0] OP_RESULT   = 3'd2;
  localparam logic [2:0] OP_STATUS   = 3'd3;
  localparam logic [2:0] OP_DIGESTS  = 3'd4;
  localparam logic [2:0] OP_ABORT    = 3'd5;
  localparam logic [2:0] OP_CLEAR    = 3'd6;
  localparam logic [2:0] OP_RESERVED = 3'd7;

  typedef enum logic [1:0] {
    IDLE      = 2'd0,
    SEARCHING = 2'd1,
    FLUSH     = 2'd2
  } stateT;

  localparam int STAT_FOUND     = 0;
  localparam int STAT_SEARCHING = 1;
  localparam int STAT_ABORTED   = 2;
  localparam int STAT_EXHAUSTED = 3;
  localparam int STAT_FULL      = 4;
  localparam int STAT_WIN_LSB   = 8;

  localparam logic [31:0] REJECT = 32'hFFFF_FFFF;

endpackage

// File: rtl/collision_search_controller_winner_select.sv
// Lowest-index priority encoder over the searcher found flags; returns the
// winning index and that searcher's 32-bit counter.
module search_winner_select #(
  parameter int NUM_SEARCHERS = 4
) (
  input  logic [NUM_SEARCHERS-1:0]    srchDone,
  input  logic [32*NUM_SEARCHERS-1:0] srchResult,
  output logic                        found,
  output logic [7:0]                  winIndex,
  output logic [31:0]                 winResult
);

  // NOTE: every output gets a default before the loop, so no latch is inferred.
  always_comb begin
    found     = 1'b0;
    winIndex  = '0;
    winResult = '0;
    // Scan from the top down so the lowest set index is the last one written.
    for (int k = NUM_SEARCHERS - 1; k >= 0; k--) begin
      if (srchDone[k]) begin
        found     = 1'b1;
        winIndex  = 8'(k);
        winResult = srchResult[32*k +: 32];
      end
    end
  end

endmodule

// File: rtl/collision_search_controller.sv
// Nios II custom-instruction controller: loads the base message, launches the
// searcher array, arbitrates results and reports status.
module collision_search_controller
  import collision_search_controller_pkg::*;
#(
  parameter int NUM_SEARCHERS = 4,
  parameter int TARGET_BITS   = 5,
  parameter int MSG_BITS      = 512
) (
  input  logic                        clk,
  input  logic                        reset,
  input  logic                        clk_en,
  input  logic                        start,
  input  logic [2:0]                  n,
  input  logic [31:0]                 dataa,
  input  logic [31:0]                 datab,
  output logic                        done,
  output logic [31:0]                 result,
  output logic [MSG_BITS-1:0]         message,
  output logic                        srch_start,
  output logic                        srch_reset,
  output logic [TARGET_BITS-1:0]      srch_target,
  input  logic [NUM_SEARCHERS-1:0]    srch_done,
  input  logic [32*NUM_SEARCHERS-1:0] srch_result,
  input  logic [32*NUM_SEARCHERS-1:0] srch_digests
);

  localparam int WORDS = MSG_BITS / 64;
  localparam int CW    = $clog2(WORDS + 1);

  stateT       state;
  logic [CW-1:0] wordCount;
  logic [31:0] totalDigests, lastResult, budget;
  logic [7:0]  winnerIndex;
  logic        found, exhausted, aborted;

  logic          accept, msgFull, anyFound;
  logic [CW-1:0] loadCount;
  logic [7:0]    winIndex;
  logic [31:0]   winResult, digestSum, statusWord;

  assign accept     = start & clk_en;
  assign msgFull    = (wordCount == CW'(WORDS));
  assign loadCount  = msgFull ? wordCount : wordCount + 1'b1;
  assign srch_reset = reset || (state == FLUSH);

  search_winner_select #(.NUM_SEARCHERS(NUM_SEARCHERS)) winnerSelect (
    .srchDone  (srch_done),
    .srchResult(srch_result),
    .found     (anyFound),
    .winIndex  (winIndex),
    .winResult (winResult)
  );

  always_comb begin
    digestSum = '0;
    for (int k = 0; k < NUM_SEARCHERS; k++) digestSum += srch_digests[32*k +: 32];
  end

  always_comb begin
    statusWord                                 = '0;
    statusWord[STAT_FOUND]                     = found;
    statusWord[STAT_SEARCHING]                 = (state != IDLE);
    statusWord[STAT_ABORTED]                   = aborted;
    statusWord[STAT_EXHAUSTED]                 = exhausted;
    statusWord[STAT_FULL]                      = msgFull;
    statusWord[STAT_WIN_LSB +: 8]              = winnerIndex;
  end

  // NOTE: all state updates use non-blocking assignments so every register
  // samples pre-edge values regardless of statement order.
  always_ff @(posedge clk) begin
    if (reset) begin
      state        <= IDLE;
      done         <= 1'b0;
      result       <= '0;
      srch_start   <= 1'b0;
      srch_target  <= '0;
      message      <= '0;
      wordCount    <= '0;
      totalDigests <= '0;
      lastResult   <= '0;
      budget       <= '0;
      winnerIndex  <= '0;
      found        <= 1'b0;
      exhausted    <= 1'b0;
      aborted      <= 1'b0;
    end else begin
      done       <= accept;
      result     <= '0;
      srch_start <= 1'b0;

      if (accept) begin
        case (n)
          OP_LOAD:
            if (state == IDLE) begin
              message   <= MSG_BITS'({message, dataa, datab});
              wordCount <= loadCount;
              result    <= 32'(loadCount);
            end else result <= REJECT;
          OP_START:
            if (state == IDLE && msgFull) begin
              srch_target  <= dataa[TARGET_BITS-1:0];
              budget       <= datab;
              totalDigests <= '0;
              found        <= 1'b0;
              exhausted    <= 1'b0;
              aborted      <= 1'b0;
              srch_start   <= 1'b1;
              state        <= SEARCHING;
              result       <= 32'd1;
            end else result <= REJECT;
          OP_RESULT:  result <= lastResult;
          OP_STATUS:  result <= statusWord;
          OP_DIGESTS: result <= totalDigests;
          OP_ABORT:   result <= (state == SEARCHING) ? 32'd1 : 32'd0;
          OP_CLEAR:
            if (state == IDLE) begin
              message   <= '0;
              wordCount <= '0;
              result    <= 32'd1;
            end else result <= REJECT;
          default:    result <= '0;
        endcase
      end

      // Termination priority: found, then budget exhausted, then abort.
      case (state)
        SEARCHING: begin
          totalDigests <= digestSum;
          if (anyFound) begin
            found       <= 1'b1;
            lastResult  <= winResult;
            winnerIndex <= winIndex;
            state       <= FLUSH;
          end else if (budget != '0 && digestSum >= budget) begin
            exhausted <= 1'b1;
            state     <= FLUSH;
          end else if (accept && n == OP_ABORT) begin
            aborted <= 1'b1;
            state   <= FLUSH;
          end
        end
        FLUSH:   state <= IDLE;
        default: ;
      endcase
    end
  end

endmodule

// File: doc/collision_search_controller.md
Name: collision_search_controller

Overview:
- Parametrised Nios II extended custom-instruction controller for the SHA-1 partial-collision search.
- Accumulates the base message and launches NUM_SEARCHERS external searchers with a target.
- Arbitrates their results, sums digests, enforces an optional digest budget, supports abort, and reports a packed status word.
- Sits between the CPU custom-instruction port and the searcher array; searchers connect through flattened vector ports.

Parameters:
- NUM_SEARCHERS, 4, number of searchers attached (1..256).
- TARGET_BITS, 5, width of the collision target taken from dataa[TARGET_BITS-1:0] (1..32).
- MSG_BITS, 512, base message width; must be a multiple of 64.

Ports:
- clk  in  1  system clock; one clock domain.
- reset  in  1  synchronous, active-high reset.
- clk_en  in  1  instruction clock enable.
- start  in  1  instruction start; accepted only when start & clk_en.
- n  in  3  opcode select.
- dataa  in  32  operand A.
- datab  in  32  operand B.
- done  out  1  one-cycle completion pulse.
- result  out  32  instruction result; valid while done=1.
- message  out  MSG_BITS  accumulated base message to the searchers.
- srch_start  out  1  one-cycle launch pulse to all searchers.
- srch_reset  out  1  searcher reset, high when reset=1 or state=FLUSH.
- srch_target  out  TARGET_BITS  latched target.
- srch_done  in  NUM_SEARCHERS  per-searcher found flag.
- srch_result  in  32*NUM_SEARCHERS  per-searcher counter; searcher k occupies bits [32k+31:32k].
- srch_digests  in  32*NUM_SEARCHERS  per-searcher digest counts, same packing.

Behaviour:
- Reset (sync): state IDLE; done=0, result=0, srch_start=0, srch_target=0, message=0, word count=0, total digests=0, last result=0, winner index=0, all flags=0.
- Instruction handshake: accept on start & clk_en. done pulses exactly one cycle, on the cycle after acceptance, with result registered. Back-to-back accepts are each answered one cycle later.
- Opcode 0, LOAD: message <= {message[MSG_BITS-65:0], dataa, datab}. Word count saturates at MSG_BITS/64; the shift still occurs when full. Result = new word count. Rejected in SEARCHING/FLUSH: result 0xFFFF_FFFF, no change.
- Opcode 1, START: legal only in IDLE with word count = MSG_BITS/64.
  - Latches target <= dataa[TARGET_BITS-1:0] and budget <= datab (0 = unlimited).
  - Clears total digests and the found/exhausted/aborted flags.
  - srch_start is high the following cycle; state <= SEARCHING.
  - Result 1 if accepted, 0xFFFF_FFFF if rejected (rejection has no effect).
- Opcode 2: result = last collision counter.
- Opcode 3, status: bit0 found, bit1 searching (state != IDLE), bit2 aborted, bit3 exhausted, bit4 message full, bits15:8 winner index, other bits 0.
- Opcode 4: result = total digests.
- Opcode 5, ABORT: in SEARCHING, set aborted and go to FLUSH, result 1. Otherwise result 0, no effect.
- Opcode 6, CLEAR: message=0, word count=0, result 1. Rejected during SEARCHING/FLUSH with result 0xFFFF_FFFF.
- Opcode 7: result 0.
- States:
  - IDLE: waits for START.
  - SEARCHING: each cycle, total digests <= sum of all srch_digests (32-bit, wraps).
    - Any srch_done: lowest-index set bit wins; latch its result and index; set found; go to FLUSH.
    - Else budget != 0 and sum >= budget: set exhausted; go to FLUSH.
    - Else accepted ABORT: as above.
  - FLUSH: srch_reset=1 for exactly one cycle; total digests frozen; then IDLE.
- Priority within one cycle: found > exhausted > abort. An ABORT that loses still returns 1, but aborted stays 0.
- srch_done is ignored outside SEARCHING.
- The message is stable from START acceptance until the return to IDLE.
- Reset mid-search: immediate return to IDLE with all state cleared; srch_reset high during reset.

Decomposition:
- Shared package: opcode constants (OP_LOAD..OP_RESERVED), state encoding, status bit positions, REJECT=32'hFFFF_FFFF.
- One natural sub-module: search_winner_select, a parametrised lowest-index priority encoder that outputs the found flag, index and muxed 32-bit result.
- The digest adder is inline.

Test Plan:
- 8 LOADs (NUM_SEARCHERS=4) with distinct words -> results 1..8; message equals the concatenation with the last pair at the LSB; status bit4=1.
- START target 5'h13, budget 0 after a full load -> result 1; srch_start pulses one cycle later; srch_target=0x13; status bit1=1.
- During search, srch_done=4'b1010 with results 0x100/0x200/0x300/0x400 -> last result 0x200, index 1; srch_reset high one cycle; status = 0x0000_0111.
- START with budget 1000, srch_digests 100 each per step rising -> exhausted when sum >= 1000; status bit3=1, bit0=0; a simultaneous srch_done instead yields found.
- ABORT mid-search -> result 1, FLUSH then IDLE, status bit2=1. A START before the message is full -> result 0xFFFF_FFFF with no srch_start; a LOAD during search -> 0xFFFF_FFFF with message unchanged.
- Assert reset during SEARCHING -> next cycle state IDLE, all outputs zero, srch_reset high during reset.
